tensor_core_sequencer: RTL and testbench
========================================

# tensor_core_sequencer

Sequences one complete tensor-core operation around the tensor core register file.
- Streams operand bytes from a valid/ready source into the file through its single-entry (non-bulk) write port.
- Starts the tensor core, waits for completion (with a watchdog), then commits the result with the file's bulk-write port.
- Streams the 16-byte result matrix (bank 0) out over a valid/ready sink.

## Interface
- NUMBER_OF_REGISTERS, 32, operand registers loaded per operation (multiple of 16)
- TIMEOUT_CYCLES, 1024, maximum compute cycles before abort
- clock_in  input  1  system clock
- reset_n_in  input  1  reset; asynchronous, active-low
- start_in  input  1  begin operation (honoured only in IDLE)
- load_data_in  input  8  operand byte
- load_valid_in  input  1  operand byte valid
- load_ready_out  output  1  sequencer accepts operand byte
- non_bulk_write_enable_out  output  1  register-file single write enable
- non_bulk_write_register_address_out  output  $clog2(NUMBER_OF_REGISTERS)  write address
- non_bulk_write_data_out  output  8  write data
- compute_start_out  output  1  one-cycle tensor-core start pulse
- compute_done_in  input  1  tensor core finished
- bulk_write_enable_out  output  1  register-file bulk write enable
- read_data_in  input  8 × [BANKS][4][4]  register-file read array; BANKS = (NUMBER_OF_REGISTERS-1)/16+1
- result_data_out  output  8  result byte
- result_valid_out  output  1  result byte valid
- result_ready_in  input  1  sink accepts result byte
- busy_out  output  1  high in any state but IDLE
- done_out  output  1  one-cycle pulse on completion
- error_out  output  1  sticky watchdog-timeout flag

## Operation
- States: IDLE, LOAD, COMPUTE, WRITEBACK, READOUT.
- IDLE
  - start_in=1 → LOAD; error_out cleared; load counter = 0.
- LOAD
  - load_ready_out=1.
  - Handshake (load_valid_in & load_ready_out) drives these combinationally in the same cycle: non_bulk_write_enable_out=1, address = load counter, data = load_data_in.
  - Counter increments per handshake.
  - Handshake at address NUMBER_OF_REGISTERS-1 → COMPUTE.
  - Address order is linear 0..N-1: address a lands in bank a/16, row (a%16)/4, column a%4.
- COMPUTE
  - compute_start_out=1 in the first cycle only; timeout counter cleared.
  - compute_done_in is ignored in that first cycle and sampled from the second cycle on.
  - done → WRITEBACK.
  - If the timeout counter reaches TIMEOUT_CYCLES without done: error_out set, → IDLE, no writeback, no done_out.
- WRITEBACK
  - bulk_write_enable_out=1 for exactly one cycle → READOUT.
- READOUT
  - result_valid_out=1.
  - result_data_out = read_data_in[0][idx/4][idx%4], combinational; idx runs 0..15.
  - Handshake increments idx.
  - Handshake at idx 15 → IDLE with done_out=1 in that same cycle.
  - result_data_out holds stable while valid and not ready.
- Stray inputs
  - start_in outside IDLE is ignored.
  - compute_done_in outside COMPUTE is ignored.
  - load_valid_in outside LOAD is ignored (no write).
- Reset (any time, including mid-operation)
  - State → IDLE; all counters → 0; error_out=0.
  - Register-file contents are not touched.

## Timing
- Reset values: every output 0 (load_ready_out, result_valid_out, busy_out, done_out, error_out, all write enables, address, data).
- Load: zero added latency; one byte per cycle at full throughput; 32 bytes take 32 handshake cycles minimum.
- Start to first load_ready_out: 1 cycle.
- compute_start_out asserts the cycle after the final load handshake.
- Done sampled in cycle k → bulk_write_enable_out in cycle k+1 → result_valid_out in k+2. The bulk write commits at the k+1 edge, so readout sees the new data.
- Readout: one byte per cycle when result_ready_in is held high; minimum 16 cycles.
- Timeout: error_out rises on the cycle after the TIMEOUT_CYCLES-th post-start cycle.
- Counter widths: load $clog2(NUMBER_OF_REGISTERS), readout 4 bits, timeout $clog2(TIMEOUT_CYCLES+1). No wrap within an operation.

## Structure
- Shared package tensor_core_pkg:
  - state enum sequencer_state_t.
  - constants MATRIX_DIM=4, MATRIX_ELEMENTS=16, BANKS function of NUMBER_OF_REGISTERS.
- One sub-module is natural: tensor_core_stream_counter (clear, increment-on-handshake, last-flag). It is instantiated for the load path and the readout path.
- FSM and watchdog live in the top.

## Test plan
- Full op, no stalls: start; bytes 0x01..0x20. Writes hit addresses 0..31 in order. compute_start pulses once. done after 5 cycles. bulk_write_enable 1 cycle. Core writes bank0 = 0xA0..0xAF → result stream 0xA0..0xAF, then done_out pulse.
- Backpressure: random gaps in load_valid_in and result_ready_in. No lost or duplicated bytes; result_data_out stable during stall.
- Timeout with TIMEOUT_CYCLES=8 and done never asserted: error_out=1 eight cycles after start pulse; no bulk write; return to IDLE. Next start clears error_out.
- Spurious inputs: compute_done_in high in the start-pulse cycle and during LOAD, start_in during READOUT. All ignored; sequence identical to scenario 1.
- Reset asserted mid-LOAD at address 13: all outputs 0 immediately. Next start reloads from address 0.
- Back-to-back: start_in high in the cycle done_out pulses is ignored. Start in the next IDLE cycle runs a second full op correctly.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared state type, matrix geometry and bank-count helper for the tensor core sequencer.
package tensor_core_pkg;

    localparam int MATRIX_DIM      = 4;
    localparam int MATRIX_ELEMENTS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_WRITEBACK,
        ST_READOUT
    } sequencer_state_t;

    function automatic int banks_f(input int number_of_registers);
        return (number_of_registers - 1) / MATRIX_ELEMENTS + 1;
    endfunction

endpackage

// File: rtl/tensor_core_stream_counter.sv
// tensor_core_stream_counter: handshake-driven element counter with synchronous clear and a last-element flag.
module tensor_core_stream_counter #(
    parameter int WIDTH = 4,
    parameter int LAST  = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb count_d = clear_i ? '0 : inc_i ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;
    assign last_o  = count_q == WIDTH'(LAST);

endmodule

// File: rtl/tensor_core_sequencer.sv
// tensor_core_sequencer: loads operands into the register file, runs the tensor core under a watchdog,
// commits the result with a bulk write and streams bank 0 out.
module tensor_core_sequencer
    import tensor_core_pkg::*;
#(
    parameter int  NUMBER_OF_REGISTERS = 32,
    parameter int  TIMEOUT_CYCLES      = 1024,
    localparam int BANKS               = banks_f(NUMBER_OF_REGISTERS),
    localparam int AW                  = $clog2(NUMBER_OF_REGISTERS),
    localparam int TW                  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                                   clock_in,
    input  logic                                                   reset_n_in,
    input  logic                                                   start_in,
    input  logic [7:0]                                             load_data_in,
    input  logic                                                   load_valid_in,
    output logic                                                   load_ready_out,
    output logic                                                   non_bulk_write_enable_out,
    output logic [AW-1:0]                                          non_bulk_write_register_address_out,
    output logic [7:0]                                             non_bulk_write_data_out,
    output logic                                                   compute_start_out,
    input  logic                                                   compute_done_in,
    output logic                                                   bulk_write_enable_out,
    input  logic [BANKS-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][7:0] read_data_in,
    output logic [7:0]                                             result_data_out,
    output logic                                                   result_valid_out,
    input  logic                                                   result_ready_in,
    output logic                                                   busy_out,
    output logic                                                   done_out,
    output logic                                                   error_out
);

    sequencer_state_t state_q, state_d;
    logic             first_q, first_d;
    logic             error_q, error_d;
    logic [TW-1:0]    timeout_q, timeout_d;
    logic [TW-1:0]    timeout_inc;
    logic [AW-1:0]    load_count;
    logic [3:0]       read_count;
    logic             load_last, read_last, load_hs, read_hs;
    logic             unused_read_data;

    tensor_core_stream_counter #(.WIDTH(AW), .LAST(NUMBER_OF_REGISTERS - 1)) u_load_counter (
        .clk_i   (clock_in),
        .rst_ni  (reset_n_in),
        .clear_i (state_q == ST_IDLE),
        .inc_i   (load_hs),
        .count_o (load_count),
        .last_o  (load_last)
    );

    tensor_core_stream_counter #(.WIDTH(4), .LAST(MATRIX_ELEMENTS - 1)) u_read_counter (
        .clk_i   (clock_in),
        .rst_ni  (reset_n_in),
        .clear_i (state_q != ST_READOUT),
        .inc_i   (read_hs),
        .count_o (read_count),
        .last_o  (read_last)
    );

    assign load_ready_out                      = state_q == ST_LOAD;
    assign load_hs                             = load_valid_in & load_ready_out;
    assign non_bulk_write_enable_out           = load_hs;
    assign non_bulk_write_register_address_out = load_hs ? load_count : '0;
    assign non_bulk_write_data_out             = load_hs ? load_data_in : '0;
    assign compute_start_out                   = (state_q == ST_COMPUTE) & first_q;
    assign bulk_write_enable_out               = state_q == ST_WRITEBACK;
    assign result_valid_out                    = state_q == ST_READOUT;
    assign read_hs                             = result_valid_out & result_ready_in;
    assign result_data_out                     = result_valid_out ? read_data_in[0][read_count[3:2]][read_count[1:0]] : '0;
    assign busy_out                            = state_q != ST_IDLE;
    assign done_out                            = read_hs & read_last;
    assign error_out                           = error_q;
    assign timeout_inc                         = timeout_q + 1'b1;
    // Only bank 0 is streamed out; the remaining banks are visible to the core, not to this block.
    assign unused_read_data                    = ^read_data_in;

    // compute_done_in is ignored in the start-pulse cycle, so the watchdog only counts from the cycle after.
    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        error_d   = error_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                state_d = start_in ? ST_LOAD : ST_IDLE;
                error_d = start_in ? 1'b0 : error_q;
            end
            ST_LOAD: begin
                state_d = (load_hs && load_last) ? ST_COMPUTE : ST_LOAD;
                first_d = load_hs && load_last;
            end
            ST_COMPUTE: begin
                if (first_q) timeout_d = '0;
                else if (compute_done_in) state_d = ST_WRITEBACK;
                else if (timeout_inc == TW'(TIMEOUT_CYCLES)) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else timeout_d = timeout_inc;
            end
            ST_WRITEBACK: state_d = ST_READOUT;
            ST_READOUT:   state_d = (read_hs && read_last) ? ST_IDLE : ST_READOUT;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= ST_IDLE;
            first_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// tb_tensor_core_sequencer: randomized operations against a transaction-level model of load, compute,
// watchdog and readout, with the bench acting as register file and tensor core.
module tb_tensor_core_sequencer;

    localparam int N = 32;
    localparam int T = 8;

    logic                       clock_in, reset_n_in, start_in, load_valid_in, load_ready_out;
    logic [7:0]                 load_data_in, non_bulk_write_data_out, result_data_out;
    logic                       non_bulk_write_enable_out, compute_start_out, compute_done_in;
    logic [4:0]                 non_bulk_write_register_address_out;
    logic                       bulk_write_enable_out, result_valid_out, result_ready_in;
    logic                       busy_out, done_out, error_out;
    logic [1:0][3:0][3:0][7:0]  read_data_in;
    logic [7:0]                 rf [N];
    logic [7:0]                 core_res [16];
    int                         n_tests, n_fail;
    logic                       err_exp;

    tensor_core_sequencer #(.NUMBER_OF_REGISTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clock_in                            (clock_in),
        .reset_n_in                          (reset_n_in),
        .start_in                            (start_in),
        .load_data_in                        (load_data_in),
        .load_valid_in                       (load_valid_in),
        .load_ready_out                      (load_ready_out),
        .non_bulk_write_enable_out           (non_bulk_write_enable_out),
        .non_bulk_write_register_address_out (non_bulk_write_register_address_out),
        .non_bulk_write_data_out             (non_bulk_write_data_out),
        .compute_start_out                   (compute_start_out),
        .compute_done_in                     (compute_done_in),
        .bulk_write_enable_out               (bulk_write_enable_out),
        .read_data_in                        (read_data_in),
        .result_data_out                     (result_data_out),
        .result_valid_out                    (result_valid_out),
        .result_ready_in                     (result_ready_in),
        .busy_out                            (busy_out),
        .done_out                            (done_out),
        .error_out                           (error_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Register file: single writes from the sequencer, bulk write commits the core's result into bank 0.
    always @(posedge clock_in) begin
        if (non_bulk_write_enable_out) rf[non_bulk_write_register_address_out] <= non_bulk_write_data_out;
        if (bulk_write_enable_out) for (int i = 0; i < 16; i++) rf[i] <= core_res[i];
    end

    always_comb begin
        read_data_in = '0;
        for (int a = 0; a < N; a++) read_data_in[a / 16][(a % 16) / 4][a % 4] = rf[a];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    task automatic obs;
        @(negedge clock_in);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {load_ready_out, non_bulk_write_enable_out, non_bulk_write_register_address_out,
                    non_bulk_write_data_out, compute_start_out, bulk_write_enable_out, result_data_out,
                    result_valid_out, busy_out, done_out, error_out}, 32'h0);
    endtask

    // done_lat: post-start cycle in which done is raised (0 = never); spur: stray inputs everywhere;
    // abort_at: load address at which reset is asserted (-1 = none); fixed: directed data patterns.
    task automatic run_op(input int gap, input int done_lat, input bit spur, input int abort_at, input bit fixed);
        logic [7:0] bytes [N];
        logic [7:0] res [16];
        int nb, idx, guard, lim;
        for (int i = 0; i < N; i++) bytes[i] = fixed ? 8'(i + 1) : 8'($urandom);
        for (int i = 0; i < 16; i++) res[i] = fixed ? 8'(8'hA0 + i) : 8'($urandom);
        for (int i = 0; i < 16; i++) core_res[i] = res[i];
        tick;
        start_in = 1'b1;
        obs;
        check("idle_busy", busy_out, 0);
        check("idle_ready", load_ready_out, 0);
        check("idle_err", error_out, err_exp);
        nb = 0;
        guard = 0;
        while (nb < N && guard < 1000) begin
            tick;
            guard++;
            start_in = 1'b0;
            load_valid_in = $urandom_range(99) >= gap;
            compute_done_in = spur ? 1'($urandom_range(1)) : 1'b0;
            if (nb == abort_at) begin
                load_valid_in = 1'b1;
                reset_n_in = 1'b0;
            end
            load_data_in = load_valid_in ? bytes[nb] : 8'($urandom);
            obs;
            if (nb == abort_at) begin
                check_all_zero("abort_outs");
                tick;
                reset_n_in = 1'b1;
                load_valid_in = 1'b0;
                compute_done_in = 1'b0;
                err_exp = 1'b0;
                return;
            end
            check("ld_ready", load_ready_out, 1);
            check("ld_err", error_out, 0);
            check("ld_cstart", compute_start_out, 0);
            check("ld_we", non_bulk_write_enable_out, load_valid_in);
            if (load_valid_in) begin
                check("ld_addr", non_bulk_write_register_address_out, nb);
                check("ld_data", non_bulk_write_data_out, bytes[nb]);
                nb++;
            end
        end
        if (nb < N) begin
            check("ld_bound", 0, 1);
            return;
        end
        tick;
        load_valid_in = spur;
        compute_done_in = spur;
        obs;
        check("c0_start", compute_start_out, 1);
        check("c0_busy", busy_out, 1);
        check("c0_we", non_bulk_write_enable_out, 0);
        lim = done_lat != 0 ? done_lat : T + 1;
        for (int k = 1; k <= lim; k++) begin
            tick;
            compute_done_in = done_lat != 0 && k == done_lat;
            obs;
            if (done_lat == 0 && k == T + 1) begin
                check("to_err", error_out, 1);
                check("to_busy", busy_out, 0);
                check("to_bulk", bulk_write_enable_out, 0);
                err_exp = 1'b1;
                load_valid_in = 1'b0;
                compute_done_in = 1'b0;
                return;
            end
            check("c_cstart", compute_start_out, 0);
            check("c_err", error_out, 0);
            check("c_bulk", bulk_write_enable_out, 0);
            check("c_busy", busy_out, 1);
        end
        tick;
        compute_done_in = spur;
        obs;
        check("wb_bulk", bulk_write_enable_out, 1);
        check("wb_valid", result_valid_out, 0);
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 1000) begin
            tick;
            guard++;
            result_ready_in = $urandom_range(99) >= gap;
            start_in = spur;
            compute_done_in = spur ? 1'($urandom_range(1)) : 1'b0;
            obs;
            check("rd_valid", result_valid_out, 1);
            check("rd_data", result_data_out, res[idx]);
            check("rd_bulk", bulk_write_enable_out, 0);
            check("rd_we", non_bulk_write_enable_out, 0);
            check("rd_done", done_out, result_ready_in && idx == 15);
            if (result_ready_in) idx++;
        end
        if (idx < 16) check("rd_bound", 0, 1);
        tick;
        start_in = 1'b0;
        result_ready_in = 1'b0;
        load_valid_in = 1'b0;
        compute_done_in = 1'b0;
        obs;
        check("end_busy", busy_out, 0);
        check("end_done", done_out, 0);
        check("end_valid", result_valid_out, 0);
        err_exp = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        err_exp = 1'b0;
        reset_n_in = 1'b0;
        start_in = 1'b0;
        load_valid_in = 1'b0;
        load_data_in = 8'h0;
        compute_done_in = 1'b0;
        result_ready_in = 1'b0;
        repeat (2) tick;
        obs;
        check_all_zero("rst_outs");
        tick;
        reset_n_in = 1'b1;
        obs;
        check_all_zero("post_rst_outs");
        run_op(0, 5, 1'b0, -1, 1'b1);
        for (int i = 0; i < 4; i++) run_op(40, $urandom_range(1, T), 1'b0, -1, 1'b0);
        run_op(0, 0, 1'b0, -1, 1'b0);
        run_op(0, 5, 1'b0, -1, 1'b0);
        run_op(0, 5, 1'b1, -1, 1'b1);
        run_op(0, 5, 1'b0, -1, 1'b0);
        run_op(20, 5, 1'b0, 13, 1'b0);
        run_op(0, 5, 1'b0, -1, 1'b1);
        run_op(30, T, 1'b1, -1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
